delay_mlab_ctrl: RTL
====================

Name: delay_mlab_ctrl

Overview:
- Runtime-programmable controller for an MLAB ring-buffer delay line. It drives an external simple dual-port MLAB (registered write, unregistered read) and tags every entry with a valid bit.
- The latency can be changed without a reconfiguration of the fabric. The block drains old traffic, scrubs stale entries, then re-arms at the new latency.
- It sits between a streaming producer and consumer in the shell datapath, replacing fixed-latency delay lines where latency is tuned at run time.

Parameters:
- WIDTH, 32, payload width.
- ADDR_WIDTH, 5, MLAB address width; ring depth D = 2**ADDR_WIDTH.
- MIN_LAT, 2, smallest legal latency.
- MAX_LAT, 32, largest legal latency; must be <= D (elaboration assertion).
- DEFAULT_LAT, 5, latency after reset; must be within [MIN_LAT, MAX_LAT].

Ports:
- clk  in  1  single clock.
- sclr  in  1  synchronous active-high reset.
- din  in  WIDTH  payload.
- din_valid  in  1  payload qualifier.
- din_ready  out  1  high only in RUN; din_valid while din_ready=0 is not accepted (producer holds).
- cfg_latency  in  6  requested latency.
- cfg_load  in  1  one-cycle request to apply cfg_latency.
- cfg_ack  out  1  one-cycle pulse on entering RUN after a reconfig.
- cfg_err  out  1  one-cycle pulse when cfg_latency was clamped.
- cur_latency  out  6  active latency.
- busy  out  1  high in DRAIN or SCRUB.
- mem_wena  out  1  MLAB write enable.
- mem_waddr  out  ADDR_WIDTH  write address (registered).
- mem_wdata  out  WIDTH+1  {valid, payload} (registered).
- mem_raddr  out  ADDR_WIDTH  read address.
- mem_rdata  in  WIDTH+1  {valid, payload}, combinational from mem_raddr.
- dout  out  WIDTH  delayed payload.
- dout_valid  out  1  delayed qualifier.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on sclr.
- Reset values:
  - state = SCRUB, scrub counter = 0, cur_latency = DEFAULT_LAT.
  - raddr = 0; din_ready, cfg_ack, cfg_err, dout_valid = 0; busy = 1.
  - dout = 0 while dout_valid = 0 (payload gated by the valid bit).
- Memory model: a write presented in cycle t is readable from cycle t+1. mem_raddr increments by 1 every cycle in every state, wrapping modulo D.
- Latency contract in RUN: a beat accepted (din_valid & din_ready) in cycle t appears on dout with dout_valid=1 in exactly cycle t+cur_latency. Idle cycles propagate as dout_valid=0.
- Write address is raddr + fixed offset derived from cur_latency and the pipeline stages; it is recomputed only on a latency change.
- mem_wena = 1 in all states. A non-accepted cycle writes valid=0.
- States:
  - SCRUB: writes {0, 0} to every address, one per cycle, with the scrub pointer independent of raddr. After D cycles, go to RUN; pulse cfg_ack if entry was via reconfig. dout_valid forced 0.
  - RUN: din_ready=1. cfg_load latches clamp(cfg_latency), pulses cfg_err if clamped, and goes to DRAIN. The beat accepted in the cfg_load cycle is delivered at the old latency.
  - DRAIN: din_ready=0; writes valid=0. After old cur_latency cycles all in-flight beats have emerged on dout at the old latency. Then cur_latency <= latched value and go to SCRUB.
- Clamp: cfg_latency < MIN_LAT becomes MIN_LAT; > MAX_LAT becomes MAX_LAT.
- cfg_load in DRAIN or SCRUB is ignored: no ack, no err, latched value unchanged.
- cfg_load with a value equal to cur_latency still performs the full DRAIN and SCRUB sequence.
- sclr mid-DRAIN or mid-SCRUB: in-flight data is lost, the pending latency is discarded, and the block returns to the reset state with DEFAULT_LAT.
- Wrap: all pointers are modulo D. The counters are sized so that the DRAIN count reaching MAX_LAT and the SCRUB count reaching D do not overflow.

Decomposition:
- Shared package delay_mlab_pkg:
  - state enum {SCRUB, RUN, DRAIN};
  - the pipeline offset constant relating write and read pointers;
  - a clamp function;
  - the counter width localparam clog2(MAX(D, MAX_LAT)+1).
- One sub-module, delay_mlab_ptr: the raddr/waddr generator with load-offset input.
- The MLAB primitive stays external.

Test Plan:
- Reset: sclr for 1 cycle -> busy=1 and din_ready=0 for exactly 32 cycles, then din_ready=1, cur_latency=5, dout_valid=0 throughout.
- Fixed stream at L=5: 100 beats with random valid gaps, payload = cycle number -> each beat emerges exactly 5 cycles later, gaps preserved, no extra dout_valid.
- Reconfig 5->12 with 5 beats in flight: cfg_load=1, cfg_latency=12 -> all 5 beats delivered at latency 5; DRAIN 5 cycles, SCRUB 32 cycles; cfg_ack pulses once; subsequent beats delivered at latency 12.
- Clamp: cfg_latency=40 -> cfg_err pulse, cur_latency=32 after ack; cfg_latency=1 -> cfg_err, cur_latency=2; a beat at L=2 arrives 2 cycles later.
- Ignored load: cfg_load with 9 during SCRUB -> no ack, no err, cur_latency unchanged.
- Mid-operation reset: sclr during DRAIN with beats in flight -> no stale dout_valid afterwards, cur_latency=5, normal operation after 32-cycle scrub.

Source files
------------

// File: rtl/delay_mlab_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// delay_mlab_pkg : shared types and helpers for the MLAB delay-line controller
// Rev 1.0
// ---------------------------------------------------------------------------
package delay_mlab_pkg;

    localparam int LAT_W = 6;

    typedef enum logic [1:0] {
        ST_SCRUB = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Write port is registered once, so the write pointer leads by latency-1.
    localparam int WR_PIPE = 1;

    function automatic int cnt_width(input int depth, input int max_lat);
        int m;
        m = (depth > max_lat) ? depth : max_lat;
        return $clog2(m + 1);
    endfunction

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] v,
                                                    input int lo, input int hi);
        if (int'(v) < lo)      return LAT_W'(lo);
        else if (int'(v) > hi) return LAT_W'(hi);
        else                   return v;
    endfunction

    function automatic logic lat_out_of_range(input logic [LAT_W-1:0] v,
                                              input int lo, input int hi);
        return (int'(v) < lo) || (int'(v) > hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_mlab_ptr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// delay_mlab_ptr : free-running read pointer plus offset-derived write pointer
// Rev 1.0
// ---------------------------------------------------------------------------
module delay_mlab_ptr
    import delay_mlab_pkg::*;
#(
    parameter int ADDR_WIDTH   = 5,
    parameter int RESET_OFFSET = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_offset,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic [ADDR_WIDTH-1:0] o_waddr_nxt
);

    localparam logic [ADDR_WIDTH-1:0] c_RESET_OFF = ADDR_WIDTH'(RESET_OFFSET);
    localparam logic [ADDR_WIDTH-1:0] c_PIPE      = ADDR_WIDTH'(WR_PIPE);

    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [ADDR_WIDTH-1:0] r_offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr  <= '0;
            r_offset <= c_RESET_OFF;
        end else begin
            r_raddr <= r_raddr + ADDR_WIDTH'(1);
            if (i_load)
                r_offset <= i_offset;
        end
    end

    assign o_raddr     = r_raddr;
    // Address to be presented next cycle, aligned with next cycle's raddr.
    assign o_waddr_nxt = r_raddr + c_PIPE + r_offset;

endmodule
`default_nettype wire

// File: rtl/delay_mlab_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// delay_mlab_ctrl : run-time programmable MLAB ring-buffer delay line control
// Rev 1.0
// ---------------------------------------------------------------------------
module delay_mlab_ctrl
    import delay_mlab_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int MIN_LAT     = 2,
    parameter int MAX_LAT     = 32,
    parameter int DEFAULT_LAT = 5
)(
    input  logic                  clk,
    input  logic                  sclr,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [LAT_W-1:0]      cfg_latency,
    input  logic                  cfg_load,
    output logic                  cfg_ack,
    output logic                  cfg_err,
    output logic [LAT_W-1:0]      cur_latency,
    output logic                  busy,
    output logic                  mem_wena,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [WIDTH:0]        mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [WIDTH:0]        mem_rdata,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid
);

    localparam int c_DEPTH = 2**ADDR_WIDTH;
    localparam int c_CNT_W = cnt_width(c_DEPTH, MAX_LAT);
    localparam logic [c_CNT_W-1:0] c_SCRUB_LAST = c_CNT_W'(c_DEPTH - 1);
    localparam logic [LAT_W-1:0]   c_DEFAULT    = LAT_W'(DEFAULT_LAT);

    generate
        if (MAX_LAT > c_DEPTH || DEFAULT_LAT < MIN_LAT || DEFAULT_LAT > MAX_LAT) begin : g_param_chk
            $error("delay_mlab_ctrl: illegal latency parameters");
        end
    endgenerate

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [LAT_W-1:0]      r_cur_lat;
    logic [LAT_W-1:0]      r_pend_lat;
    logic                  r_reconf;
    logic                  r_ack;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_mem_waddr;
    logic [WIDTH:0]        r_mem_wdata;

    logic                  w_accept;
    logic                  w_drain_done;
    logic                  w_scrub_done;
    logic                  w_rd_valid;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [ADDR_WIDTH-1:0] w_waddr_nxt;
    logic [ADDR_WIDTH-1:0] w_new_offset;

    assign w_accept     = din_valid && (r_state == ST_RUN);
    assign w_drain_done = (r_state == ST_DRAIN) && (r_cnt == c_CNT_W'(r_cur_lat));
    assign w_scrub_done = (r_state == ST_SCRUB) && (r_cnt == c_SCRUB_LAST);
    assign w_new_offset = ADDR_WIDTH'(r_pend_lat - LAT_W'(WR_PIPE));

    delay_mlab_ptr #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .RESET_OFFSET(DEFAULT_LAT - WR_PIPE)
    ) u_ptr (
        .clk        (clk),
        .rst        (sclr),
        .i_load     (w_drain_done),
        .i_offset   (w_new_offset),
        .o_raddr    (w_raddr),
        .o_waddr_nxt(w_waddr_nxt)
    );

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state    <= ST_SCRUB;
            r_cnt      <= '0;
            r_cur_lat  <= c_DEFAULT;
            r_pend_lat <= c_DEFAULT;
            r_reconf   <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_SCRUB: begin
                    if (w_scrub_done) begin
                        r_state  <= ST_RUN;
                        r_cnt    <= '0;
                        r_ack    <= r_reconf;
                        r_reconf <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cfg_load) begin
                        r_pend_lat <= clamp_lat(cfg_latency, MIN_LAT, MAX_LAT);
                        r_err      <= lat_out_of_range(cfg_latency, MIN_LAT, MAX_LAT);
                        r_state    <= ST_DRAIN;
                        r_cnt      <= c_CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_cur_lat <= r_pend_lat;
                        r_state   <= ST_SCRUB;
                        r_cnt     <= '0;
                        r_reconf  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_SCRUB;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Scrub address 0 is staged on the cycle before SCRUB so the whole ring
    // is cleared while SCRUB is active and readable on the first RUN cycle.
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
        end else if ((r_state == ST_SCRUB) && !w_scrub_done) begin
            r_mem_waddr <= r_cnt[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
            r_mem_wdata <= '0;
        end else if (w_drain_done) begin
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_waddr <= w_waddr_nxt;
            r_mem_wdata <= {w_accept, (w_accept ? din : {WIDTH{1'b0}})};
        end
    end

    assign w_rd_valid  = mem_rdata[WIDTH] && (r_state != ST_SCRUB);

    assign din_ready   = (r_state == ST_RUN);
    assign busy        = (r_state != ST_RUN);
    assign cfg_ack     = r_ack;
    assign cfg_err     = r_err;
    assign cur_latency = r_cur_lat;
    assign mem_wena    = 1'b1;
    assign mem_waddr   = r_mem_waddr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_raddr   = w_raddr;
    assign dout_valid  = w_rd_valid;
    assign dout        = w_rd_valid ? mem_rdata[WIDTH-1:0] : {WIDTH{1'b0}};

endmodule
`default_nettype wire
